multicycle_ctrl: RTL

Main control FSM for the multicycle MIPS datapath. Sequences one instruction through fetch, decode, execute, memory and writeback, reusing the shared ALU/operation block every cycle. Drives its ALUSrc/ALUOp selects, register-file and memory strobes, and PC update. Waits on a memory-ready handshake, so memory latency may vary.

---
 rtl/multicycle_ctrl.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multicycle MIPS datapath.
// Steps one instruction through fetch, decode, execute, memory and writeback,
// and waits on MemReady so memory latency may vary.
// Optional retired-instruction counter: define MULTICYCLE_CTRL_RETIRE_CNT_EN
// to add the RetireCnt output.
module multicycle_ctrl #(
    parameter int unsigned OPW = 6,
    parameter int unsigned STW = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           Run,
    input  logic [OPW-1:0] Opcode,
    input  logic           Zero,
    input  logic           MemReady,
    output logic           PCWrite,
    output logic           IorD,
    output logic           MemRead,
    output logic           MemWrite,
    output logic           IRWrite,
    output logic           RegDst,
    output logic           MemtoReg,
    output logic           RegWrite,
    output logic           ALUSrcA,
    output logic [1:0]     ALUSrcB,
    output logic [1:0]     ALUOp,
    output logic [1:0]     PCSource,
    output logic           Busy,
    output logic           Illegal,
    output logic [STW-1:0] State
`ifdef MULTICYCLE_CTRL_RETIRE_CNT_EN
    ,
    output logic [31:0]    RetireCnt
`endif
);

    localparam logic [OPW-1:0] OpLw    = OPW'(6'b100011);
    localparam logic [OPW-1:0] OpSw    = OPW'(6'b101011);
    localparam logic [OPW-1:0] OpRtype = OPW'(6'b000000);
    localparam logic [OPW-1:0] OpBeq   = OPW'(6'b000100);
    localparam logic [OPW-1:0] OpAddi  = OPW'(6'b001000);
    localparam logic [OPW-1:0] OpAndi  = OPW'(6'b001100);
    localparam logic [OPW-1:0] OpOri   = OPW'(6'b001101);
    localparam logic [OPW-1:0] OpSlti  = OPW'(6'b001010);
    localparam logic [OPW-1:0] OpJ     = OPW'(6'b000010);

    typedef enum logic [3:0] {
        StIdle    = 4'd0,
        StFetch   = 4'd1,
        StDecode  = 4'd2,
        StMemAdr  = 4'd3,
        StMemRd   = 4'd4,
        StMemWb   = 4'd5,
        StMemWr   = 4'd6,
        StRtypeEx = 4'd7,
        StRtypeWb = 4'd8,
        StBranch  = 4'd9,
        StItypeEx = 4'd10,
        StItypeWb = 4'd11,
        StJump    = 4'd12
    } state_e;

    state_e state;
    state_e end_state;

    logic op_mem;
    logic op_sw;
    logic op_rtype;
    logic op_beq;
    logic op_itype;
    logic op_jump;
    logic op_legal;

    // Opcode class decode; unknown or X opcodes fall to the default and read as illegal
    always_comb begin
        op_mem   = 1'b0;
        op_rtype = 1'b0;
        op_beq   = 1'b0;
        op_itype = 1'b0;
        op_jump  = 1'b0;
        case (Opcode)
            OpLw, OpSw:                     op_mem   = 1'b1;
            OpRtype:                        op_rtype = 1'b1;
            OpBeq:                          op_beq   = 1'b1;
            OpAddi, OpAndi, OpOri, OpSlti:  op_itype = 1'b1;
            OpJ:                            op_jump  = 1'b1;
            default: ;
        endcase
        op_sw     = (Opcode == OpSw);
        op_legal  = op_mem | op_rtype | op_beq | op_itype | op_jump;
        // Instruction boundary: Run is only looked at here and in IDLE
        end_state = Run ? StFetch : StIdle;
    end

    // State register and transitions
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= StIdle;
        end else begin
            case (state)
                StIdle:    if (Run) state <= StFetch;
                StFetch:   if (MemReady) state <= StDecode;
                StDecode: begin
                    if (op_mem)        state <= StMemAdr;
                    else if (op_rtype) state <= StRtypeEx;
                    else if (op_beq)   state <= StBranch;
                    else if (op_itype) state <= StItypeEx;
                    else if (op_jump)  state <= StJump;
                    else               state <= end_state;
                end
                StMemAdr:  state <= op_sw ? StMemWr : StMemRd;
                StMemRd:   if (MemReady) state <= StMemWb;
                StMemWb:   state <= end_state;
                StMemWr:   if (MemReady) state <= end_state;
                StRtypeEx: state <= StRtypeWb;
                StRtypeWb: state <= end_state;
                StBranch:  state <= end_state;
                StItypeEx: state <= StItypeWb;
                StItypeWb: state <= end_state;
                StJump:    state <= end_state;
                default:   state <= StIdle;
            endcase
        end
    end

    // Control outputs decoded from the state; only FETCH/BRANCH strobes see inputs
    always_comb begin
        PCWrite  = 1'b0;
        IorD     = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        IRWrite  = 1'b0;
        RegDst   = 1'b0;
        MemtoReg = 1'b0;
        RegWrite = 1'b0;
        ALUSrcA  = 1'b0;
        ALUSrcB  = 2'b00;
        ALUOp    = 2'b00;
        PCSource = 2'b00;
        Illegal  = 1'b0;
        Busy     = (state != StIdle);
        State    = STW'(state);
        case (state)
            StFetch: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = MemReady;
                PCWrite = MemReady;
            end
            StDecode: begin
                ALUSrcB = 2'b11;
                Illegal = ~op_legal;
            end
            StMemAdr: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            StMemRd: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            StMemWb: begin
                MemtoReg = 1'b1;
                RegWrite = 1'b1;
            end
            StMemWr: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            StRtypeEx: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
            end
            StRtypeWb: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
            end
            StBranch: begin
                ALUSrcA  = 1'b1;
                ALUOp    = 2'b01;
                PCSource = 2'b01;
                PCWrite  = Zero;
            end
            StItypeEx: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                ALUOp   = 2'b11;
            end
            StItypeWb: begin
                RegWrite = 1'b1;
            end
            StJump: begin
                PCSource = 2'b10;
                PCWrite  = 1'b1;
            end
            default: ;
        endcase
    end

`ifdef MULTICYCLE_CTRL_RETIRE_CNT_EN
    logic retire;

    // A legal instruction retires in the cycle its final state is left
    always_comb begin
        retire = (state == StMemWb) || (state == StRtypeWb) || (state == StBranch) ||
                 (state == StItypeWb) || (state == StJump) ||
                 ((state == StMemWr) && MemReady);
    end

    // Retired-instruction counter, wraps naturally at 2^32
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            RetireCnt <= 32'd0;
        end else if (retire) begin
            RetireCnt <= RetireCnt + 32'd1;
        end
    end
`endif

endmodule
